// File: rtl/mux_arb_pkg.sv
// Shared types and helpers for the round-robin select-line arbiter.
// Holds the fixed requester count, select width, FSM state type and the
// round-robin pick function used by mux_rr_pick.
package mux_arb_pkg;

  localparam int N_REQ = 8;
  localparam int SEL_W = 3;

  typedef enum logic {
    IDLE = 1'b0,  // output register empty
    HOLD = 1'b1   // output register holds an item awaiting out_ready
  } arb_state_t;

  typedef struct packed {
    logic             found;
    logic [SEL_W-1:0] idx;
  } pick_t;

  // First set req bit scanning upward from ptr+1, wrapping modulo N_REQ.
  // The loop walks offsets from farthest to nearest so the nearest hit is
  // the last one written and therefore wins.
  function automatic pick_t rr_pick(input logic [N_REQ-1:0] req,
                                    input logic [SEL_W-1:0] ptr);
    pick_t            p;
    logic [SEL_W-1:0] lane;
    p = '0;
    for (int k = N_REQ; k >= 1; k--) begin
      lane = ptr + k[SEL_W-1:0];
      if (req[lane]) begin
        p.found = 1'b1;
        p.idx   = lane;
      end
    end
    return p;
  endfunction

endpackage

// File: rtl/mux_rr_pick.sv
// Combinational winner selection for mux_rr_arbiter.
// Default build: round-robin starting after ptr.
// With MUX_ARB_FIXED_PRIO_EN defined: fixed priority, lowest index wins,
// and the ptr input does not exist.
module mux_rr_pick
  import mux_arb_pkg::*;
(
`ifndef MUX_ARB_FIXED_PRIO_EN
  input  logic [SEL_W-1:0] ptr,
`endif
  input  logic [N_REQ-1:0] req,
  output logic             valid,
  output logic [SEL_W-1:0] idx
);

`ifdef MUX_ARB_FIXED_PRIO_EN

  // Priority encoder: scan high to low so the lowest set index is written last.
  always_comb begin
    // NOTE: every output gets a default at the top of the block so no path
    // leaves it unassigned, which would otherwise infer a latch.
    valid = |req;
    idx   = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (req[i]) idx = i[SEL_W-1:0];
    end
  end

`else

  pick_t pick;

  // Round-robin scan from ptr+1.
  always_comb begin
    pick  = rr_pick(req, ptr);
    valid = pick.found;
    idx   = pick.idx;
  end

`endif

endmodule

// File: rtl/mux_rr_arbiter.sv
// Round-robin scheduler for a shared 8:1 select datapath with a
// valid/ready output register.
// Optional build macro: MUX_ARB_FIXED_PRIO_EN switches the picker to fixed
// priority (lowest index wins) and removes the rotating pointer.
module mux_rr_arbiter
  import mux_arb_pkg::*;
#(
  parameter int N  = N_REQ,
  parameter int DW = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N-1:0]      req,
  input  logic [N*DW-1:0]   din,
  output logic [N-1:0]      gnt,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DW-1:0]     out_data,
  output logic [SEL_W-1:0]  out_sel
);

  arb_state_t       state;
  logic             pick_valid;
  logic [SEL_W-1:0] pick_idx;
  logic             capture;
  logic [DW-1:0]    lane_data;

`ifndef MUX_ARB_FIXED_PRIO_EN
  // Last granted lane; the next scan starts just above it.
  logic [SEL_W-1:0] ptr;
`endif

  mux_rr_pick u_pick (
`ifndef MUX_ARB_FIXED_PRIO_EN
    .ptr   (ptr),
`endif
    .req   (req),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  // Decide whether a capture happens this cycle and pulse the matching grant.
  // Reset suppresses grants because no capture can take effect on that edge.
  always_comb begin
    capture = 1'b0;
    gnt     = '0;
    if (rst_n) begin
      unique case (state)
        IDLE:    capture = pick_valid;
        HOLD:    capture = out_ready && pick_valid;
        default: capture = 1'b0;
      endcase
    end
    if (capture) gnt[pick_idx] = 1'b1;
  end

  // Lane mux feeding the output register.
  always_comb begin
    lane_data = din[int'(pick_idx)*DW +: DW];
  end

  // FSM, output register and round-robin pointer.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!rst_n) begin
      state    <= IDLE;
      out_data <= '0;
      out_sel  <= '0;
`ifndef MUX_ARB_FIXED_PRIO_EN
      ptr      <= SEL_W'(N_REQ - 1);
`endif
    end else begin
      unique case (state)
        IDLE:    if (capture) state <= HOLD;
        HOLD:    if (out_ready && !capture) state <= IDLE;
        default: state <= IDLE;
      endcase
      if (capture) begin
        out_data <= lane_data;
        out_sel  <= pick_idx;
`ifndef MUX_ARB_FIXED_PRIO_EN
        ptr      <= pick_idx;
`endif
      end
    end
  end

  assign out_valid = (state == HOLD);

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Directed self-checking bench for mux_rr_arbiter.
// Inputs change 1 time unit after the rising edge; outputs are checked
// 2 time units after the rising edge, well clear of both clock edges.
module tb_mux_rr_arbiter;

  localparam int DW = 8;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [7:0]      req;
  logic [8*DW-1:0] din;
  logic [7:0]      gnt;
  logic            out_valid;
  logic            out_ready;
  logic [DW-1:0]   out_data;
  logic [2:0]      out_sel;

  int n_chk  = 0;
  int n_pass = 0;

  mux_rr_arbiter #(.N(8), .DW(DW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .din       (din),
    .gnt       (gnt),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_sel   (out_sel)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp)
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    else
      n_pass++;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // Lane i carries 8'hA0 | i.
    for (int i = 0; i < 8; i++) din[i*DW +: DW] = 8'hA0 | 8'(i);
    rst_n     = 1'b0;
    req       = 8'hFF;
    out_ready = 1'b1;
    tick;
    tick;
    #1;
    check("rst_valid", 32'(out_valid), 32'h0);
    check("rst_data",  32'(out_data),  32'h0);
    check("rst_sel",   32'(out_sel),   32'h0);
    check("rst_gnt",   32'(gnt),       32'h0);

`ifdef MUX_ARB_FIXED_PRIO_EN
    rst_n = 1'b1;
    #1;
    check("fp_first_gnt", 32'(gnt), 32'h01);
    for (int k = 0; k < 3; k++) begin
      tick; #1;
      check("fp_gnt_ff", 32'(gnt),     32'h01);
      check("fp_sel_ff", 32'(out_sel), 32'h0);
    end
    req = 8'hF0;
    #1;
    check("fp_gnt_f0", 32'(gnt), 32'h10);
    tick; #1;
    check("fp_sel4",   32'(out_sel),  32'h4);
    check("fp_data4",  32'(out_data), 32'hA4);
    check("fp_gnt_f0b", 32'(gnt),     32'h10);
    out_ready = 1'b0;
    #1;
    check("fp_stall_gnt", 32'(gnt),       32'h0);
    check("fp_stall_vld", 32'(out_valid), 32'h1);
`else
    // Fairness sweep: all lanes requesting, out_ready high.
    rst_n = 1'b1;
    #1;
    check("first_gnt",   32'(gnt),       32'h01);
    check("first_valid", 32'(out_valid), 32'h0);
    for (int k = 1; k <= 8; k++) begin
      tick; #1;
      check("sweep_gnt",   32'(gnt),       32'(8'h01 << (k % 8)));
      check("sweep_valid", 32'(out_valid), 32'h1);
      check("sweep_sel",   32'(out_sel),   32'(k - 1));
      check("sweep_data",  32'(out_data),  32'(8'hA0 | 8'(k - 1)));
    end
    // Drain: lane 0 held, ptr = 0.
    tick;
    req = 8'h00;
    #1;
    check("drain_gnt", 32'(gnt),       32'h0);
    check("drain_sel", 32'(out_sel),   32'h0);
    check("drain_vld", 32'(out_valid), 32'h1);
    tick; #1;
    check("drain_idle", 32'(out_valid), 32'h0);

    // Lanes 2 and 5 with a stalled consumer.
    req       = 8'h24;
    out_ready = 1'b0;
    #1;
    check("stall_gnt2", 32'(gnt), 32'h04);
    tick;
    req = 8'h20;
    for (int s = 0; s < 5; s++) begin
      #1;
      check("stall_gnt0",  32'(gnt),       32'h0);
      check("stall_data",  32'(out_data),  32'hA2);
      check("stall_sel",   32'(out_sel),   32'h2);
      check("stall_valid", 32'(out_valid), 32'h1);
      tick;
    end
    out_ready = 1'b1;
    #1;
    check("accept_gnt5",  32'(gnt),      32'h20);
    check("accept_data2", 32'(out_data), 32'hA2);
    tick;
    req = 8'h00;
    #1;
    check("next_data5", 32'(out_data), 32'hA5);
    check("next_sel5",  32'(out_sel),  32'h5);
    check("next_gnt0",  32'(gnt),      32'h0);
    tick; #1;
    check("idle_after5", 32'(out_valid), 32'h0);

    // Pointer wrap: lane 6, then lane 7, then lane 0.
    req = 8'h40;
    #1;
    check("wrap_gnt6", 32'(gnt), 32'h40);
    tick;
    req = 8'h80;
    #1;
    check("wrap_gnt7", 32'(gnt),     32'h80);
    check("wrap_sel6", 32'(out_sel), 32'h6);
    tick;
    req = 8'h01;
    #1;
    check("wrap_gnt0", 32'(gnt),     32'h01);
    check("wrap_sel7", 32'(out_sel), 32'h7);
    tick;
    // ptr = 0 now: lanes 0 and 7 pending, scan 1..7 reaches 7 first.
    req = 8'h81;
    #1;
    check("wrap_pick7", 32'(gnt),     32'h80);
    check("wrap_sel0",  32'(out_sel), 32'h0);
    tick;
    req = 8'h01;
    #1;
    check("wrap_pick0", 32'(gnt), 32'h01);
    tick;

    // Accept with no requests: back to IDLE, then a late request.
    req = 8'h00;
    #1;
    check("empty_vld", 32'(out_valid), 32'h1);
    check("empty_sel", 32'(out_sel),   32'h0);
    tick; #1;
    check("empty_idle", 32'(out_valid), 32'h0);
    tick; #1;
    check("empty_gnt",  32'(gnt),       32'h0);
    check("empty_idle2", 32'(out_valid), 32'h0);
    tick;
    req = 8'h08;
    #1;
    check("late_gnt3", 32'(gnt), 32'h08);
    tick;
    req       = 8'h00;
    out_ready = 1'b0;
    #1;
    check("late_vld",  32'(out_valid), 32'h1);
    check("late_sel",  32'(out_sel),   32'h3);
    check("late_data", 32'(out_data),  32'hA3);

    // Reset while holding an item.
    tick;
    rst_n = 1'b0;
    req   = 8'hFF;
    #1;
    check("rst_hold_gnt", 32'(gnt), 32'h0);
    tick; #1;
    check("rst_hold_vld", 32'(out_valid), 32'h0);
    check("rst_hold_gnt2", 32'(gnt),      32'h0);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    #1;
    check("post_rst_gnt0", 32'(gnt), 32'h01);
    tick; #1;
    check("post_rst_sel",  32'(out_sel), 32'h0);
    check("post_rst_gnt1", 32'(gnt),     32'h02);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
